// File: rtl/mul_div_unit_divider_pkg.sv
// ---------------------------------------------------------------------------
// mul_div_unit_divider_pkg
//   Shared MIPS definitions for the iterative divider:
//   - FSM state encoding of the divider sequencer.
//   - DIV/DIVU funct codes the control unit decodes to drive start/signed.
// ---------------------------------------------------------------------------
package mul_div_unit_divider_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } div_state_t;

    // R-type funct field values for the two divide instructions.
    localparam logic [5:0] FUNCT_DIV  = 6'h1A;  // signed divide
    localparam logic [5:0] FUNCT_DIVU = 6'h1B;  // unsigned divide

endpackage : mul_div_unit_divider_pkg

// File: rtl/mul_div_unit_divider_div_step.sv
// ---------------------------------------------------------------------------
// mul_div_unit_divider_div_step
//   One restoring-division iteration, purely combinational.
//   The {rem, quo} pair is shifted left by one, a WIDTH+1 bit trial
//   subtraction of the divisor is made, and either the difference is kept
//   (quotient bit 1) or the shifted remainder is restored (quotient bit 0).
//
// Ports:
//   rem       in   WIDTH  partial remainder before this iteration
//   quo       in   WIDTH  working dividend / quotient before this iteration
//   divisor   in   WIDTH  magnitude of the divisor
//   rem_next  out  WIDTH  partial remainder after this iteration
//   quo_next  out  WIDTH  working dividend / quotient after this iteration
// ---------------------------------------------------------------------------
module mul_div_unit_divider_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] trial;
    logic           borrow;

    // The remainder is always below the divisor, so after the shift it
    // needs one extra bit; a WIDTH+1 bit difference is then exact and its
    // MSB is a clean borrow flag.
    assign rem_shift = {rem, quo[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, divisor};
    assign borrow    = trial[WIDTH];

    // On borrow the shifted remainder is below the divisor, so it fits in
    // WIDTH bits and can be restored directly.
    assign rem_next = borrow ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], ~borrow};

endmodule : mul_div_unit_divider_div_step

// File: rtl/mul_div_unit_divider.sv
// ---------------------------------------------------------------------------
// mul_div_unit_divider
//   Multi-cycle restoring divider for MIPS DIV/DIVU. Quotient feeds LO,
//   remainder feeds HI. Fixed latency: the start is accepted on edge E0,
//   WIDTH iterations run on E1..E(WIDTH), results and a one-cycle done
//   pulse are registered on E(WIDTH+1). No early exit.
//
// Ports:
//   clk_i          in   1      clock, rising edge
//   rst_i          in   1      asynchronous reset, active high
//   start_in       in   1      request a divide (only honoured in IDLE)
//   signed_in      in   1      1 = DIV (two's complement), 0 = DIVU
//   dividend_in    in   WIDTH  dividend, captured when start is accepted
//   divisor_in     in   WIDTH  divisor, captured when start is accepted
//   busy_out       out  1      divide in progress
//   done_out       out  1      one-cycle pulse, results valid from here on
//   quotient_out   out  WIDTH  quotient (LO)
//   remainder_out  out  WIDTH  remainder (HI)
//   div_zero_out   out  1      divisor was zero, held with the results
// ---------------------------------------------------------------------------
module mul_div_unit_divider
    import mul_div_unit_divider_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_in,
    input  logic             signed_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out,
    output logic             div_zero_out
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_t       state;
    div_state_t       state_next;

    logic             load;
    logic             iterate;
    logic             finish;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] dividend_raw_q;
    logic             neg_dividend_q;
    logic             neg_divisor_q;
    logic             div_zero_q;

    logic             neg_dividend;
    logic             neg_divisor;
    logic [WIDTH-1:0] abs_dividend;
    logic [WIDTH-1:0] abs_divisor;

    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] quo_final;
    logic [WIDTH-1:0] rem_final;

    // -----------------------------------------------------------------------
    // Operand conditioning. Negating 0x80000000 wraps to itself, which is
    // exactly its magnitude when read as unsigned, so no special case.
    // -----------------------------------------------------------------------
    assign neg_dividend = signed_in & dividend_in[WIDTH-1];
    assign neg_divisor  = signed_in & divisor_in[WIDTH-1];
    assign abs_dividend = neg_dividend ? -dividend_in : dividend_in;
    assign abs_divisor  = neg_divisor  ? -divisor_in  : divisor_in;

    // -----------------------------------------------------------------------
    // Single iteration cell, reused every CALC cycle.
    // -----------------------------------------------------------------------
    mul_div_unit_divider_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    // -----------------------------------------------------------------------
    // FSM state register.
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and datapath strobes.
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        iterate    = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_in) begin
                    load       = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                iterate = 1'b1;
                if (cnt == LAST_ITER) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Working registers. Starts are only seen through `load`, which is
    // only raised in IDLE, so a start during a divide has no effect.
    // -----------------------------------------------------------------------
    // NOTE: the working registers are plain flops, not a memory, so they
    // are cleared by reset along with the control state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt            <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            divisor_q      <= '0;
            dividend_raw_q <= '0;
            neg_dividend_q <= 1'b0;
            neg_divisor_q  <= 1'b0;
            div_zero_q     <= 1'b0;
        end else if (load) begin
            cnt            <= '0;
            rem_q          <= '0;
            quo_q          <= abs_dividend;
            divisor_q      <= abs_divisor;
            dividend_raw_q <= dividend_in;
            neg_dividend_q <= neg_dividend;
            neg_divisor_q  <= neg_divisor;
            div_zero_q     <= (divisor_in == '0);
        end else if (iterate) begin
            cnt   <= cnt + CNT_W'(1);
            rem_q <= rem_step;
            quo_q <= quo_step;
        end
    end

    // -----------------------------------------------------------------------
    // Sign correction and divide-by-zero override, applied in FINISH.
    // The remainder follows the dividend's sign so that
    // dividend = quotient * divisor + remainder holds in two's complement.
    // -----------------------------------------------------------------------
    always_comb begin
        quo_final = quo_q;
        rem_final = rem_q;
        if (div_zero_q) begin
            quo_final = '1;
            rem_final = dividend_raw_q;
        end else begin
            if (neg_dividend_q ^ neg_divisor_q) begin
                quo_final = -quo_q;
            end
            if (neg_dividend_q) begin
                rem_final = -rem_q;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output registers. Results only move on the FINISH edge, so HI/LO
    // readers see stable values for the whole of the next divide.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
            quotient_out  <= '0;
            remainder_out <= '0;
            div_zero_out  <= 1'b0;
        end else begin
            done_out <= finish;
            if (load) begin
                busy_out <= 1'b1;
            end else if (finish) begin
                busy_out <= 1'b0;
            end
            if (finish) begin
                quotient_out  <= quo_final;
                remainder_out <= rem_final;
                div_zero_out  <= div_zero_q;
            end
        end
    end

endmodule : mul_div_unit_divider

// File: tb/tb_mul_div_unit_divider.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit_divider
//   Directed vectors for the iterative divider with hand-computed results.
//   Latency is counted in rising edges including the accepting edge E0,
//   so a correct divide reports 34.
// ---------------------------------------------------------------------------
module tb_mul_div_unit_divider;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 34;

    logic             clk_i;
    logic             rst_i;
    logic             start_in;
    logic             signed_in;
    logic [WIDTH-1:0] dividend_in;
    logic [WIDTH-1:0] divisor_in;
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] quotient_out;
    logic [WIDTH-1:0] remainder_out;
    logic             div_zero_out;

    int vectors;
    int miscompares;

    mul_div_unit_divider #(
        .WIDTH (WIDTH),
        .CNT_W (6)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_in      (start_in),
        .signed_in     (signed_in),
        .dividend_in   (dividend_in),
        .divisor_in    (divisor_in),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .quotient_out  (quotient_out),
        .remainder_out (remainder_out),
        .div_zero_out  (div_zero_out)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Present operands with start high, let the next edge accept them, then
    // scramble the operand inputs to show they are not re-sampled.
    task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        signed_in   = sgn;
        dividend_in = a;
        divisor_in  = b;
        start_in    = 1'b1;
        @(posedge clk_i);
        #1;
        start_in    = 1'b0;
        signed_in   = ~sgn;
        dividend_in = 32'hDEAD_BEEF;
        divisor_in  = 32'h0BAD_F00D;
    endtask

    // Continue counting edges from `from` until done_out is seen, bounded.
    task automatic wait_done(input int from, output int edges);
        edges = from;
        while (!done_out && edges < 200) begin
            @(posedge clk_i);
            #1;
            edges++;
        end
    endtask

    task automatic run_case(input string tag, input logic sgn,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_q, input logic [31:0] exp_r,
                            input logic exp_z);
        int edges;
        logic [31:0] prev_q;
        prev_q = quotient_out;
        launch(sgn, a, b);
        check({tag, "_busy"}, {31'd0, busy_out}, 32'd1);
        wait_done(1, edges);
        check({tag, "_latency"}, edges, LATENCY);
        check({tag, "_quo"}, quotient_out, exp_q);
        check({tag, "_rem"}, remainder_out, exp_r);
        check({tag, "_dz"}, {31'd0, div_zero_out}, {31'd0, exp_z});
        @(posedge clk_i);
        #1;
        check({tag, "_done_pulse"}, {31'd0, done_out}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy_out}, 32'd0);
        // quotient must not have been disturbed before FINISH; prev_q is only
        // used to keep the value live for the log when debugging
        if (prev_q === 32'hx) $display("note: previous quotient unknown");
    endtask

    initial begin
        int edges;
        int seen_done;

        vectors     = 0;
        miscompares = 0;
        rst_i       = 1'b1;
        start_in    = 1'b0;
        signed_in   = 1'b0;
        dividend_in = '0;
        divisor_in  = '0;

        repeat (3) @(posedge clk_i);
        #1;
        check("rst_busy", {31'd0, busy_out}, 32'd0);
        check("rst_done", {31'd0, done_out}, 32'd0);
        check("rst_quo",  quotient_out, 32'd0);
        check("rst_rem",  remainder_out, 32'd0);
        check("rst_dz",   {31'd0, div_zero_out}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Outputs must hold during CALC: quotient stays at reset value mid-run.
        launch(1'b0, 32'd100, 32'd7);
        repeat (5) @(posedge clk_i);
        #1;
        check("divu100_hold", quotient_out, 32'd0);
        wait_done(6, edges);
        check("divu100_latency", edges, LATENCY);
        check("divu100_quo", quotient_out, 32'd14);
        check("divu100_rem", remainder_out, 32'd2);
        check("divu100_dz", {31'd0, div_zero_out}, 32'd0);
        @(posedge clk_i);
        #1;
        check("divu100_pulse", {31'd0, done_out}, 32'd0);

        run_case("div_m7_2",  1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_case("div_7_m2",  1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        1'b0);
        run_case("div_ovf",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0);
        run_case("divu_max",  1'b0, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0);
        run_case("divu_zero", 1'b0, 32'h1234_5678, 32'd0,        32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        run_case("divu_big",  1'b0, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);

        // Start pulsed mid-divide is ignored.
        launch(1'b0, 32'd50, 32'd5);
        repeat (9) @(posedge clk_i);
        #1;
        signed_in   = 1'b1;
        dividend_in = 32'd99;
        divisor_in  = 32'd9;
        start_in    = 1'b1;
        @(posedge clk_i);
        #1;
        start_in = 1'b0;
        wait_done(11, edges);
        check("ign_latency", edges, LATENCY);
        check("ign_quo", quotient_out, 32'd10);
        check("ign_rem", remainder_out, 32'd0);

        // Start during the done cycle is accepted immediately.
        launch(1'b0, 32'd1000, 32'd10);
        check("b2b_busy", {31'd0, busy_out}, 32'd1);
        check("b2b_done_low", {31'd0, done_out}, 32'd0);
        wait_done(1, edges);
        check("b2b_latency", edges, LATENCY);
        check("b2b_quo", quotient_out, 32'd100);
        check("b2b_rem", remainder_out, 32'd0);
        @(posedge clk_i);
        #1;

        // Asynchronous reset mid-divide: outputs (currently 100/0) clear
        // before the next edge, and the aborted divide never completes.
        launch(1'b0, 32'd77, 32'd7);
        repeat (14) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy_out}, 32'd0);
        check("arst_done", {31'd0, done_out}, 32'd0);
        check("arst_quo",  quotient_out, 32'd0);
        check("arst_rem",  remainder_out, 32'd0);
        check("arst_dz",   {31'd0, div_zero_out}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_i);
            #1;
            if (done_out || busy_out) seen_done++;
        end
        check("arst_no_done", seen_done, 32'd0);

        run_case("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mul_div_unit_divider
